icape_warmboot: RTL and testbench
=================================

ICAPE_WARMBOOT -- requirements
Module: icape_warmboot

Interface
REQ-001 The block SHALL have one parameter per line as name, default, meaning:
- LGTIMEOUT, 10, log2 of the per-transaction acknowledge timeout in i_clk cycles.
REQ-002 The ports SHALL be as listed below, one per line as name, direction, width, meaning:
- i_clk  in  1  sole clock.
- i_reset  in  1  synchronous, active-high reset.
- i_boot_stb  in  1  single-cycle request to warm-boot from i_boot_addr.
- i_boot_addr  in  32  warm boot start address (WBSTAR value).
- i_rd_stb  in  1  single-cycle request to read a configuration register.
- i_rd_addr  in  5  configuration register address to read.
- o_busy  out  1  sequence in progress.
- o_rd_valid  out  1  one-cycle strobe; o_rd_data is valid.
- o_rd_data  out  32  register read result.
- o_err  out  1  one-cycle strobe; a transaction timed out.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master controls.
- o_wb_addr  out  5  Wishbone word address.
- o_wb_data  out  32  Wishbone write data.
- i_wb_ack, i_wb_stall  in  1 each  Wishbone slave responses.
- i_wb_data  in  32  Wishbone read data.
REQ-003 Clocking and reset are fixed: one clock, i_clk; reset is synchronous and active-high, named i_reset.

Function
REQ-004 The FSM SHALL have exactly these states: IDLE, STAR_REQ, STAR_WAIT, CMD_REQ, CMD_WAIT, RD_REQ, RD_WAIT.
REQ-005 In IDLE, an i_boot_stb SHALL latch i_boot_addr and enter STAR_REQ on the next cycle.
REQ-006 In IDLE, an i_rd_stb without i_boot_stb SHALL latch i_rd_addr and enter RD_REQ.
REQ-007 When i_boot_stb and i_rd_stb are asserted together, boot SHALL win and the read request SHALL be discarded.
REQ-008 Any i_boot_stb or i_rd_stb arriving outside IDLE SHALL be ignored; requests are not queued.
REQ-009 o_busy SHALL equal (state != IDLE).
REQ-010 STAR_REQ SHALL drive cyc=1, stb=1, we=1, addr=5'h10, data=latched boot address.
REQ-011 The block SHALL hold stb and all request fields stable while i_wb_stall=1.
REQ-012 On the first cycle with stb=1 and i_wb_stall=0, the block SHALL drop stb on the next cycle and move to the matching WAIT state, holding cyc=1.
REQ-013 In STAR_WAIT, i_wb_ack SHALL move the FSM to CMD_REQ with cyc held high; stb is re-raised, so this is one bus cycle carrying two transactions.
REQ-014 CMD_REQ SHALL drive we=1, addr=5'h04, data=32'h0000000F (IPROG).
REQ-015 In CMD_WAIT, i_wb_ack SHALL drop cyc and return to IDLE.
REQ-016 RD_REQ SHALL drive we=0, addr=latched read address, data=0.
REQ-017 In RD_WAIT, i_wb_ack SHALL capture i_wb_data into o_rd_data, pulse o_rd_valid for 1 cycle, drop cyc, and return to IDLE.
REQ-018 At most one request SHALL be outstanding; the block SHALL not issue a new stb before the previous ack.
REQ-019 A LGTIMEOUT-bit timeout counter SHALL clear on every stb issue and increment each cycle while cyc=1 awaiting ack.
REQ-020 When the timeout counter reaches all-ones without an ack, the block SHALL drop cyc and stb, pulse o_err for 1 cycle, and return to IDLE.
REQ-021 After a timeout, o_rd_valid SHALL NOT pulse and o_rd_data SHALL be unchanged.
REQ-022 i_wb_ack while cyc=0 or in a REQ state SHALL be ignored.
REQ-023 Counter wrap-around SHALL be impossible; the timeout fires before wrap.
REQ-024 o_wb_stb SHALL never be 1 while o_wb_cyc=0.

Reset
REQ-025 i_reset SHALL force, on the next edge: state=IDLE, o_wb_cyc=0, o_wb_stb=0, o_wb_we=0, o_wb_addr=0, o_wb_data=0, o_busy=0, o_rd_valid=0, o_err=0, o_rd_data=0, timeout counter=0.
REQ-026 A reset mid-transaction SHALL abandon it silently (no o_err, no o_rd_valid), and a late ack after reset SHALL be ignored.
REQ-027 Request strobes coincident with i_reset SHALL be ignored.

Verification
REQ-028 Boot: i_boot_stb with addr 32'h0040_0000, slave stalls 7 cycles per request, acks 200 cycles later -> writes (5'h10, 32'h00400000) then (5'h04, 32'h0000000F), cyc continuous, o_busy drops after second ack.
REQ-029 Read: i_rd_stb with addr 5'h0C, slave returns 32'h0362D093 -> one read with we=0, o_rd_valid pulses once with o_rd_data=32'h0362D093.
REQ-030 Simultaneous strobes: i_boot_stb and i_rd_stb in the same cycle -> only the boot sequence runs; i_rd_stb during busy -> no read ever issued.
REQ-031 Timeout: slave never acks, LGTIMEOUT=4 -> cyc drops and o_err pulses about 15 cycles after stb accepted; FSM returns to IDLE; a subsequent read succeeds.
REQ-032 Reset mid-operation: i_reset during CMD_WAIT, ack arriving 2 cycles later -> cyc=0 after the reset edge, no o_err, no o_rd_valid, FSM in IDLE.
REQ-033 Bus protocol: assertions for REQ-011, REQ-018 and REQ-024 SHALL hold throughout all scenarios.

Source files
------------

// File: rtl/icape_warmboot.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : icape_warmboot
// Brief    : Wishbone master that writes WBSTAR then IPROG to the ICAPE for a
//            warm boot, or reads a single configuration register.
// Revision : 1.0 - initial release
// ============================================================================
module icape_warmboot #(
    parameter int LGTIMEOUT = 10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_boot_stb,
    input  logic [31:0] i_boot_addr,
    input  logic        i_rd_stb,
    input  logic [4:0]  i_rd_addr,
    output logic        o_busy,
    output logic        o_rd_valid,
    output logic [31:0] o_rd_data,
    output logic        o_err,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [4:0]  o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data
);

    localparam logic [4:0]  c_ADDR_WBSTAR = 5'h10;
    localparam logic [4:0]  c_ADDR_CMD    = 5'h04;
    localparam logic [31:0] c_CMD_IPROG   = 32'h0000_000F;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STAR_REQ  = 3'd1,
        STAR_WAIT = 3'd2,
        CMD_REQ   = 3'd3,
        CMD_WAIT  = 3'd4,
        RD_REQ    = 3'd5,
        RD_WAIT   = 3'd6
    } state_t;

    state_t                 r_state_q,     w_state_d;
    logic [31:0]            r_boot_addr_q, w_boot_addr_d;
    logic [4:0]             r_rd_addr_q,   w_rd_addr_d;
    logic [31:0]            r_rd_data_q,   w_rd_data_d;
    logic                   r_rd_valid_q,  w_rd_valid_d;
    logic                   r_err_q,       w_err_d;
    logic [LGTIMEOUT-1:0]   r_tmo_q,       w_tmo_d;

    logic w_tmo_max;
    logic w_is_req;

    assign w_tmo_max = &r_tmo_q;
    assign w_is_req  = (r_state_q == STAR_REQ) || (r_state_q == CMD_REQ) ||
                       (r_state_q == RD_REQ);

    always_comb begin
        w_state_d     = r_state_q;
        w_boot_addr_d = r_boot_addr_q;
        w_rd_addr_d   = r_rd_addr_q;
        w_rd_data_d   = r_rd_data_q;
        w_rd_valid_d  = 1'b0;
        w_err_d       = 1'b0;
        w_tmo_d       = r_tmo_q;

        if (r_state_q == IDLE) begin
            w_tmo_d = '0;
            if (i_boot_stb) begin
                w_boot_addr_d = i_boot_addr;
                w_state_d     = STAR_REQ;
            end else if (i_rd_stb) begin
                w_rd_addr_d = i_rd_addr;
                w_state_d   = RD_REQ;
            end
        end else if (w_is_req && !i_wb_stall) begin
            // Request accepted: restart the timeout for the ack phase.
            w_tmo_d = '0;
            case (r_state_q)
                STAR_REQ: w_state_d = STAR_WAIT;
                CMD_REQ:  w_state_d = CMD_WAIT;
                default:  w_state_d = RD_WAIT;
            endcase
        end else if (!w_is_req && i_wb_ack) begin
            w_tmo_d = '0;
            case (r_state_q)
                STAR_WAIT: w_state_d = CMD_REQ;
                RD_WAIT: begin
                    w_rd_data_d  = i_wb_data;
                    w_rd_valid_d = 1'b1;
                    w_state_d    = IDLE;
                end
                default:   w_state_d = IDLE;
            endcase
        end else if (w_tmo_max) begin
            // Saturation point doubles as the timeout, so the counter never wraps.
            w_tmo_d   = '0;
            w_err_d   = 1'b1;
            w_state_d = IDLE;
        end else begin
            w_tmo_d = r_tmo_q + LGTIMEOUT'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state_q     <= IDLE;
            r_boot_addr_q <= '0;
            r_rd_addr_q   <= '0;
            r_rd_data_q   <= '0;
            r_rd_valid_q  <= 1'b0;
            r_err_q       <= 1'b0;
            r_tmo_q       <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_boot_addr_q <= w_boot_addr_d;
            r_rd_addr_q   <= w_rd_addr_d;
            r_rd_data_q   <= w_rd_data_d;
            r_rd_valid_q  <= w_rd_valid_d;
            r_err_q       <= w_err_d;
            r_tmo_q       <= w_tmo_d;
        end
    end

    // Bus fields are decoded from the state so they stay put across stalls.
    always_comb begin
        o_wb_we   = 1'b0;
        o_wb_addr = 5'h00;
        o_wb_data = 32'h0;
        case (r_state_q)
            STAR_REQ, STAR_WAIT: begin
                o_wb_we   = 1'b1;
                o_wb_addr = c_ADDR_WBSTAR;
                o_wb_data = r_boot_addr_q;
            end
            CMD_REQ, CMD_WAIT: begin
                o_wb_we   = 1'b1;
                o_wb_addr = c_ADDR_CMD;
                o_wb_data = c_CMD_IPROG;
            end
            RD_REQ, RD_WAIT: begin
                o_wb_addr = r_rd_addr_q;
            end
            default: begin
                o_wb_we = 1'b0;
            end
        endcase
    end

    assign o_busy     = (r_state_q != IDLE);
    assign o_wb_cyc   = (r_state_q != IDLE);
    assign o_wb_stb   = w_is_req;
    assign o_rd_valid = r_rd_valid_q;
    assign o_rd_data  = r_rd_data_q;
    assign o_err      = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_icape_warmboot.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_icape_warmboot
// Brief    : Randomized scoreboard bench for icape_warmboot with a stalling,
//            delayed-ack Wishbone slave and protocol monitors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icape_warmboot;

    localparam int LG  = 8;
    localparam int TMO = 1 << LG;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_boot_stb;
    logic [31:0] i_boot_addr;
    logic        i_rd_stb;
    logic [4:0]  i_rd_addr;
    logic        o_busy, o_rd_valid, o_err;
    logic [31:0] o_rd_data;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [4:0]  o_wb_addr;
    logic [31:0] o_wb_data;
    logic        i_wb_ack, i_wb_stall;
    logic [31:0] i_wb_data;

    icape_warmboot #(.LGTIMEOUT(LG)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_boot_stb(i_boot_stb), .i_boot_addr(i_boot_addr),
        .i_rd_stb(i_rd_stb), .i_rd_addr(i_rd_addr),
        .o_busy(o_busy), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_err(o_err),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed { logic we; logic [4:0] addr; logic [31:0] data; } bus_t;
    typedef struct packed { logic is_err; logic [31:0] data; } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [31:0] last_rd = 32'h0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic bus_t mk_bus(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus_t b;
        b.we = we; b.addr = a; b.data = d;
        return b;
    endfunction

    function automatic rsp_t mk_rsp(input logic e, input logic [31:0] d);
        rsp_t r;
        r.is_err = e; r.data = d;
        return r;
    endfunction

    // Slave model: stall_n stall cycles per request, ack ack_dly cycles after acceptance.
    int          stall_n = 0, ack_dly = 0, stall_cnt = 0, dly_cnt = 0;
    bit          ack_en = 1'b1, pend = 1'b0;
    logic [31:0] rd_val = 32'h0;

    initial begin
        i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_data = 32'h0;
        forever begin
            @(posedge i_clk); #1;
            i_wb_ack  = 1'b0;
            i_wb_data = $urandom;
            if (pend) begin
                if (dly_cnt == 0) begin
                    i_wb_ack  = ack_en;
                    i_wb_data = rd_val;
                    pend      = 1'b0;
                end else dly_cnt--;
            end
            if (o_wb_cyc && o_wb_stb) begin
                if (stall_cnt < stall_n) begin
                    i_wb_stall = 1'b1; stall_cnt++;
                end else begin
                    i_wb_stall = 1'b0; stall_cnt = 0; pend = 1'b1; dly_cnt = ack_dly;
                end
            end else begin
                i_wb_stall = 1'b0; stall_cnt = 0;
            end
        end
    end

    // Monitor: scoreboard pops plus bus-protocol checks, sampled mid-cycle.
    longint      cyc_cnt = 0, acc_cyc = 0;
    int          n_acc = 0;
    bit          outstanding = 1'b0, prev_stall_req = 1'b0, prev_rst = 1'b0, prev_star_ack = 1'b0;
    logic        p_we;
    logic [4:0]  p_addr;
    logic [31:0] p_data;

    initial begin
        bus_t   eb;
        rsp_t   er;
        longint lat;
        forever begin
            @(negedge i_clk);
            cyc_cnt++;
            if (o_wb_stb) check("stb_implies_cyc", {31'b0, o_wb_cyc}, 32'd1);
            if (prev_stall_req && !prev_rst) begin
                check("stall_hold_stb", {31'b0, o_wb_stb}, 32'd1);
                check("stall_hold_fields",
                      {31'b0, (o_wb_we == p_we) && (o_wb_addr == p_addr) && (o_wb_data == p_data)}, 32'd1);
            end
            if (prev_star_ack)
                check("cyc_continuous", {25'b0, o_wb_cyc, o_wb_stb, o_wb_addr}, {25'b0, 2'b11, 5'h04});
            if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
                check("single_outstanding", {31'b0, outstanding}, 32'd0);
                if (bus_q.size() == 0) begin
                    check("unexpected_txn_addr", {27'b0, o_wb_addr}, 32'hFFFF_FFFF);
                end else begin
                    eb = bus_q.pop_front();
                    check("txn_we", {31'b0, o_wb_we}, {31'b0, eb.we});
                    check("txn_addr", {27'b0, o_wb_addr}, {27'b0, eb.addr});
                    check("txn_data", o_wb_data, eb.data);
                end
                outstanding = 1'b1;
                acc_cyc     = cyc_cnt;
                n_acc++;
            end
            prev_star_ack = i_wb_ack && o_wb_cyc && !o_wb_stb && o_wb_we &&
                            (o_wb_addr == 5'h10) && !i_reset;
            if ((i_wb_ack && o_wb_cyc && !o_wb_stb) || !o_wb_cyc || i_reset) outstanding = 1'b0;
            if (o_rd_valid) begin
                if (rsp_q.size() == 0) check("unexpected_rd_valid", o_rd_data, 32'hDEAD_BEEF);
                else begin
                    er = rsp_q.pop_front();
                    check("rsp_kind_rd", {31'b0, er.is_err}, 32'd0);
                    check("rd_data", o_rd_data, er.data);
                end
            end
            if (o_err) begin
                if (rsp_q.size() == 0) check("unexpected_err", {31'b0, o_err}, 32'd0);
                else begin
                    er  = rsp_q.pop_front();
                    lat = cyc_cnt - acc_cyc;
                    check("rsp_kind_err", {31'b0, er.is_err}, 32'd1);
                    check("err_rd_data_kept", o_rd_data, er.data);
                    check("err_latency_window",
                          {31'b0, (lat >= TMO - 2) && (lat <= TMO + 4)}, 32'd1);
                end
            end
            prev_stall_req = o_wb_stb && i_wb_stall;
            prev_rst       = i_reset;
            p_we = o_wb_we; p_addr = o_wb_addr; p_data = o_wb_data;
        end
    end

    task automatic tick();
        @(posedge i_clk); #1;
    endtask

    task automatic wait_idle();
        tick();
        for (int i = 0; i < 4 * TMO + 600 && o_busy; i++) tick();
        check("idle_reached", {31'b0, o_busy}, 32'd0);
        tick(); tick();
        check("all_txn_seen", bus_q.size(), 32'd0);
        check("all_rsp_seen", rsp_q.size(), 32'd0);
    endtask

    task automatic expect_boot(input logic [31:0] a, input bit acked);
        bus_q.push_back(mk_bus(1'b1, 5'h10, a));
        if (acked) bus_q.push_back(mk_bus(1'b1, 5'h04, 32'h0000_000F));
        else       rsp_q.push_back(mk_rsp(1'b1, last_rd));
    endtask

    task automatic expect_read(input logic [4:0] a, input logic [31:0] v, input bit acked);
        bus_q.push_back(mk_bus(1'b0, a, 32'h0));
        if (acked) begin
            rsp_q.push_back(mk_rsp(1'b0, v));
            last_rd = v;
        end else rsp_q.push_back(mk_rsp(1'b1, last_rd));
    endtask

    task automatic pulse(input bit boot, input bit rd, input logic [31:0] ba, input logic [4:0] ra);
        i_boot_stb = boot; i_boot_addr = ba; i_rd_stb = rd; i_rd_addr = ra;
        tick();
        i_boot_stb = 1'b0; i_rd_stb = 1'b0;
        check("busy_after_stb", {31'b0, o_busy}, 32'd1);
    endtask

    initial begin
        logic [31:0] ba, v;
        logic [4:0]  ra;
        int          mode, n0;
        bit          acked;
        i_reset = 1'b1; i_boot_stb = 1'b0; i_rd_stb = 1'b0;
        i_boot_addr = 32'h0; i_rd_addr = 5'h0;
        repeat (3) tick();
        check("rst_busy", {31'b0, o_busy}, 32'd0);
        check("rst_cyc_stb_we", {29'b0, o_wb_cyc, o_wb_stb, o_wb_we}, 32'd0);
        check("rst_addr", {27'b0, o_wb_addr}, 32'd0);
        check("rst_wdata", o_wb_data, 32'd0);
        check("rst_pulses", {30'b0, o_rd_valid, o_err}, 32'd0);
        check("rst_rd_data", o_rd_data, 32'd0);
        i_boot_stb = 1'b1; i_rd_stb = 1'b1;
        tick();
        i_boot_stb = 1'b0; i_rd_stb = 1'b0; i_reset = 1'b0;
        tick();
        check("stb_during_reset_ignored", {30'b0, o_busy, o_wb_cyc}, 32'd0);

        // Long stalls and a 200-cycle ack delay on a boot sequence.
        stall_n = 7; ack_dly = 200; ack_en = 1'b1;
        expect_boot(32'h0040_0000, 1'b1);
        pulse(1'b1, 1'b0, 32'h0040_0000, 5'h0);
        wait_idle();

        stall_n = 0; ack_dly = 2; rd_val = 32'h0362_D093;
        expect_read(5'h0C, rd_val, 1'b1);
        pulse(1'b0, 1'b1, 32'h0, 5'h0C);
        wait_idle();
        check("rd_data_held", o_rd_data, 32'h0362_D093);

        // Simultaneous strobes, then a read strobe while busy.
        expect_boot(32'h1234_5678, 1'b1);
        pulse(1'b1, 1'b1, 32'h1234_5678, 5'h03);
        wait_idle();
        expect_boot(32'h0ABC_0000, 1'b1);
        pulse(1'b1, 1'b0, 32'h0ABC_0000, 5'h0);
        tick();
        i_rd_stb = 1'b1; i_rd_addr = 5'h07;
        tick();
        i_rd_stb = 1'b0;
        wait_idle();

        // Timeout on a read, then a successful read.
        ack_en = 1'b0; ack_dly = 0;
        expect_read(5'h05, 32'h0, 1'b0);
        pulse(1'b0, 1'b1, 32'h0, 5'h05);
        wait_idle();
        ack_en = 1'b1; rd_val = 32'hCAFE_0001;
        expect_read(5'h11, rd_val, 1'b1);
        pulse(1'b0, 1'b1, 32'h0, 5'h11);
        wait_idle();

        // Reset during CMD_WAIT with the ack landing two cycles after the reset edge.
        ack_dly = 2;
        expect_boot(32'h00FF_0000, 1'b1);
        n0 = n_acc;
        pulse(1'b1, 1'b0, 32'h00FF_0000, 5'h0);
        for (int i = 0; i < 50 && n_acc < n0 + 2; i++) tick();
        check("reached_cmd_wait", n_acc, n0 + 2);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("cyc_after_reset", {30'b0, o_wb_cyc, o_busy}, 32'd0);
        last_rd = 32'h0;
        repeat (8) tick();
        check("idle_after_late_ack", {30'b0, o_wb_cyc, o_busy}, 32'd0);
        check("no_rsp_after_reset", rsp_q.size(), 32'd0);
        check("rd_data_cleared", o_rd_data, 32'd0);

        for (int it = 0; it < 40; it++) begin
            mode    = $urandom_range(0, 3);
            stall_n = $urandom_range(0, 3);
            ack_dly = $urandom_range(0, 6);
            acked   = ($urandom_range(0, 9) != 0);
            ack_en  = acked;
            ba      = $urandom;
            ra      = 5'($urandom_range(0, 31));
            v       = $urandom;
            rd_val  = v;
            if (mode == 1) begin
                expect_read(ra, v, acked);
                pulse(1'b0, 1'b1, ba, ra);
            end else begin
                expect_boot(ba, acked);
                pulse(1'b1, mode == 2, ba, ra);
                if (mode == 3) begin
                    tick();
                    i_rd_stb = 1'b1; i_rd_addr = ra;
                    tick();
                    i_rd_stb = 1'b0;
                end
            end
            wait_idle();
        end
        ack_en = 1'b1;

        repeat (5) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
